// File: rtl/alu_core_if.sv
// alu_core_if: operand/select inputs and registered result/flag outputs of the ALU
interface alu_core_if;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  ctrl;
  logic        cout;
  logic        over;
  logic        zero;
  logic [31:0] res;
  modport master (output A, B, ctrl, input cout, over, zero, res);
  modport slave  (input A, B, ctrl, output cout, over, zero, res);
endinterface

// File: rtl/alu_core.sv
// alu_core: 32-bit registered ALU with add/sub, logic, set-less-than and logical shifts
module alu_core (
  input logic       clk,
  input logic       rst,
  alu_core_if.slave bus
);
  logic [32:0] sum_add, sum_sub;
  logic        over_add, over_sub, slt, sltu;
  logic [31:0] r;
  logic        co, ov;
  assign sum_add  = {1'b0, bus.A} + {1'b0, bus.B};
  assign sum_sub  = {1'b0, bus.A} + {1'b0, ~bus.B} + 33'd1;
  assign over_add = (bus.A[31] == bus.B[31]) && (sum_add[31] != bus.A[31]);
  assign over_sub = (bus.A[31] != bus.B[31]) && (sum_sub[31] != bus.A[31]);
  // Signed compare corrects the difference sign with overflow so it holds across the full range
  assign slt  = sum_sub[31] ^ over_sub;
  assign sltu = ~sum_sub[32];
  always_comb begin
    r  = '0;
    co = 1'b0;
    ov = 1'b0;
    case (bus.ctrl)
      4'b0000: r = bus.A & bus.B;
      4'b0001: r = bus.A | bus.B;
      4'b0010: begin
        r  = sum_add[31:0];
        co = sum_add[32];
        ov = over_add;
      end
      4'b0011: r = bus.A ^ bus.B;
      4'b0101: r = {31'b0, sltu};
      4'b0110: begin
        r  = sum_sub[31:0];
        co = sum_sub[32];
        ov = over_sub;
      end
      4'b0111: r = {31'b0, slt};
      4'b1000: r = bus.A << bus.B[4:0];
      4'b1001: r = bus.A >> bus.B[4:0];
      default: r = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.res  <= '0;
      bus.cout <= 1'b0;
      bus.over <= 1'b0;
      bus.zero <= 1'b1;
    end else begin
      bus.res  <= r;
      bus.cout <= co;
      bus.over <= ov;
      bus.zero <= (r == '0);
    end
  end
endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed and random stimulus with a queued expected-result scoreboard
module tb_alu_core;
  typedef struct packed {
    logic [31:0] res;
    logic        cout;
    logic        over;
    logic        zero;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  exp_t q[$];
  alu_core_if bus ();
  alu_core dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    exp_t e;
    longint s;
    e = '0;
    case (c)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd3: e.res = a ^ b;
      4'd2: begin
        e.res  = a + b;
        e.cout = (longint'(a) + longint'(b)) > 64'sd4294967295;
        s      = longint'($signed(a)) + longint'($signed(b));
        e.over = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: begin
        e.res  = a - b;
        e.cout = (a >= b);
        s      = longint'($signed(a)) - longint'($signed(b));
        e.over = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: e.res = (a < b) ? 32'd1 : 32'd0;
      4'd7: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: e.res = a << b[4:0];
      4'd9: e.res = a >> b[4:0];
      default: e.res = '0;
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    compared++;
    assert (act === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  task automatic drive(logic [31:0] a, logic [31:0] b, logic [3:0] c, logic r, exp_t e, string tag);
    exp_t x;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.ctrl = c;
    rst = r;
    q.push_back(e);
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk({tag, ".res"}, bus.res, x.res);
    chk({tag, ".cout"}, {31'b0, bus.cout}, {31'b0, x.cout});
    chk({tag, ".over"}, {31'b0, bus.over}, {31'b0, x.over});
    chk({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, x.zero});
  endtask
  task automatic op(logic [31:0] a, logic [31:0] b, logic [3:0] c, string tag);
    drive(a, b, c, 1'b0, model(a, b, c), tag);
  endtask
  task automatic opx(logic [31:0] a, logic [31:0] b, logic [3:0] c, logic [31:0] r, logic co, logic ov, string tag);
    drive(a, b, c, 1'b0, '{res: r, cout: co, over: ov, zero: (r == 32'd0)}, tag);
  endtask
  initial begin
    bus.A = '0;
    bus.B = '0;
    bus.ctrl = '0;
    drive(32'd5, 32'd3, 4'd2, 1'b1, '{res: 32'd0, cout: 1'b0, over: 1'b0, zero: 1'b1}, "reset");
    drive(32'd5, 32'd3, 4'd2, 1'b0, '{res: 32'd8, cout: 1'b0, over: 1'b0, zero: 1'b0}, "first_after_reset");
    opx(32'd1, 32'h7FFFFFFF, 4'd2, 32'h80000000, 1'b0, 1'b1, "add_ovf");
    opx(32'hFFFFFFFF, 32'd1, 4'd2, 32'd0, 1'b1, 1'b0, "add_wrap");
    opx(32'h00AFB000, 32'hFFF10000, 4'd2, 32'h00A0B000, 1'b1, 1'b0, "add_mix");
    opx(32'h7FFFFFFF, 32'hFFFFFFFF, 4'd6, 32'h80000000, 1'b0, 1'b1, "sub_ovf_pos");
    opx(32'h80000000, 32'd1, 4'd6, 32'h7FFFFFFF, 1'b1, 1'b1, "sub_ovf_neg");
    opx(32'd1, 32'd2, 4'd6, 32'hFFFFFFFF, 1'b0, 1'b0, "sub_borrow");
    opx(32'd100, 32'd100, 4'd6, 32'd0, 1'b1, 1'b0, "sub_equal");
    opx(32'd99, 32'd100, 4'd0, 32'd96, 1'b0, 1'b0, "and");
    opx(32'd99, 32'd100, 4'd1, 32'd103, 1'b0, 1'b0, "or");
    opx(32'd99, 32'd100, 4'd3, 32'd7, 1'b0, 1'b0, "xor");
    opx(32'hFF00F00F, 32'h1F00100F, 4'd0, 32'h1F00100F, 1'b0, 1'b0, "and_mask");
    opx(32'h80000000, 32'h7FFFFFFF, 4'd7, 32'd1, 1'b0, 1'b0, "slt_min_max");
    opx(32'hFFFFFFFF, 32'h80000000, 4'd7, 32'd0, 1'b0, 1'b0, "slt_m1_min");
    opx(32'd0, 32'hFFFFFFFF, 4'd5, 32'd1, 1'b0, 1'b0, "sltu_0_max");
    opx(32'hFFFFFFFE, 32'hFFFFFFFF, 4'd5, 32'd1, 1'b0, 1'b0, "sltu_m2_m1");
    opx(32'h12345678, 32'h12345678, 4'd7, 32'd0, 1'b0, 1'b0, "slt_equal");
    opx(32'h12345678, 32'h12345678, 4'd5, 32'd0, 1'b0, 1'b0, "sltu_equal");
    opx(32'h55555555, 32'd1, 4'd8, 32'hAAAAAAAA, 1'b0, 1'b0, "sll_1");
    opx(32'h55555555, 32'd31, 4'd9, 32'd0, 1'b0, 1'b0, "srl_31");
    opx(32'hAAAAAAAA, 32'd31, 4'd9, 32'd1, 1'b0, 1'b0, "srl_zero_fill");
    opx(32'h55555555, 32'd33, 4'd8, 32'hAAAAAAAA, 1'b0, 1'b0, "sll_33");
    opx(32'h55555555, 32'd0, 4'd9, 32'h55555555, 1'b0, 1'b0, "srl_0");
    opx(32'hDEADBEEF, 32'h12345678, 4'd4, 32'd0, 1'b0, 1'b0, "undef_4");
    opx(32'hFFFFFFFF, 32'hFFFFFFFF, 4'd15, 32'd0, 1'b0, 1'b0, "undef_15");
    for (int i = 0; i < 32; i++) begin
      op(32'h55555555, i, 4'd8, "sll_sweep");
      op(32'h55555555, i, 4'd9, "srl_sweep");
    end
    for (int i = 0; i < 200; i++)
      op($urandom, $urandom, 4'($urandom_range(0, 15)), "random");
    drive(32'd7, 32'd9, 4'd2, 1'b1, '{res: 32'd0, cout: 1'b0, over: 1'b0, zero: 1'b1}, "reset_again");
    op(32'd7, 32'd9, 4'd6, "after_reset_sub");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
